cnt163_chain: RTL and testbench
===============================

CNT163_CHAIN -- requirements
Module: cnt163_chain

Interface
REQ-001 SHALL have parameter WIDTH, default 16, counter width in bits; legal values are multiples of 4 from 4 to 32 (one 4-bit slice per nibble).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port clr_n, input, 1, synchronous clear, active-low.
REQ-005 SHALL have port load_n, input, 1, synchronous parallel load, active-low.
REQ-006 SHALL have port enp, input, 1, count enable P.
REQ-007 SHALL have port ent, input, 1, count enable T (also gates rco).
REQ-008 SHALL have port d, input, WIDTH, parallel load data.
REQ-009 SHALL have port q, output, WIDTH, registered count value.
REQ-010 SHALL have port rco, output, 1, ripple carry out, combinational.
REQ-011 SHALL have port tc_valid, output, 1, registered wrap-event valid.
REQ-012 SHALL have port tc_ready, input, 1, downstream accept for the wrap event.
REQ-013 SHALL have port tc_overrun, output, 1, sticky lost-event flag.
REQ-014 SHALL have port wrap_cnt, output, 8, saturating count of wraps since last clear.

Function
REQ-015 SHALL apply per-edge priority: clr_n low > load_n low > count (enp & ent) > hold.
REQ-016 SHALL, on clear, set q to 0, wrap_cnt to 0, tc_overrun to 0; tc_valid unaffected.
REQ-017 SHALL, on load, set q = d in one cycle, independent of enp/ent.
REQ-018 SHALL, on count, set q = q + 1 mod 2^WIDTH; q = all-ones wraps to 0.
REQ-019 SHALL build the increment from 4-bit slices: slice k advances only when enp & ent and all lower slices equal 4'hF (slice 0 uses enp & ent directly).
REQ-020 SHALL drive rco = ent & (q == all-ones), combinational, no dependency on enp, clr_n or load_n.
REQ-021 SHALL define a wrap as a count edge with q == all-ones; load of all-ones or clear is never a wrap.
REQ-022 SHALL, on a wrap, set tc_valid to 1 on that edge.
REQ-023 SHALL clear tc_valid on an edge where tc_valid & tc_ready and no wrap occurs.
REQ-024 SHALL keep tc_valid at 1 when accept and a new wrap coincide (new event replaces accepted one; no overrun).
REQ-025 SHALL set tc_overrun when a wrap occurs while tc_valid = 1 and tc_ready = 0; stays set until clear or rst.
REQ-026 SHALL increment wrap_cnt on each wrap, saturating at 8'hFF.
REQ-027 SHALL ignore tc_ready when tc_valid = 0.
REQ-028 SHALL have latency: q, tc_valid, tc_overrun, wrap_cnt all update one edge after the qualifying inputs; rco same cycle as q.

Reset
REQ-029 SHALL, on rst high, immediately (no clock) force q = 0, tc_valid = 0, tc_overrun = 0, wrap_cnt = 0.
REQ-030 SHALL hold all state at reset values while rst is high, regardless of other inputs.
REQ-031 SHALL resume normal operation on the first rising clk edge after rst deasserts; rst mid-count discards the in-flight value and any pending event.

Verification
REQ-032 SHALL cover load/count: WIDTH=16, load_n=0 d=16'hFFFD, then enp=ent=1 for 3 edges -> q = FFFE, FFFF, 0000; rco = 1 only while q=FFFF; tc_valid = 1 after third edge, wrap_cnt = 1.
REQ-033 SHALL cover enable gating: q=16'h00FF, enp=0 ent=1 -> q holds, rco=0; enp=1 ent=0 at q=FFFF -> q holds, rco=0.
REQ-034 SHALL cover handshake: tc_valid=1, tc_ready=1, no wrap -> tc_valid=0 next edge; wrap coinciding with accept -> tc_valid stays 1, tc_overrun stays 0.
REQ-035 SHALL cover overrun: tc_ready=0, two wraps (WIDTH=4, 32 count edges) -> tc_valid=1, tc_overrun=1, wrap_cnt=2; clr_n=0 one edge -> q=0, tc_overrun=0, wrap_cnt=0, tc_valid still 1.
REQ-036 SHALL cover priority and reset: clr_n=0 with load_n=0 d=16'h1234 -> q=0; rst pulsed mid-cycle between edges at q=16'h8000 with tc_valid=1 -> q=0 and tc_valid=0 before next edge.
REQ-037 SHALL cover saturation: 300 wraps at WIDTH=4 with tc_ready=1 -> wrap_cnt=8'hFF, tc_overrun=0.

Source files
------------

// File: rtl/cnt163_chain.sv
// cnt163_chain: chained 74x163-style synchronous counter with a wrap-event valid/ready handshake
//   clk, rst               clock, async active-high reset
//   clr_n, load_n          sync clear / parallel load (active-low, clear wins)
//   enp, ent               count enables; ent also gates rco
//   d / q                  load data / registered count
//   rco                    ent & (q == all-ones), combinational
//   tc_valid, tc_ready     wrap event and its downstream accept
//   tc_overrun             sticky: wrap arrived while an unaccepted event was pending
//   wrap_cnt               saturating wraps since last clear
module cnt163_chain #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_n,
  input  logic             load_n,
  input  logic             enp,
  input  logic             ent,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             rco,
  output logic             tc_valid,
  input  logic             tc_ready,
  output logic             tc_overrun,
  output logic [7:0]       wrap_cnt
);
  localparam int NS = WIDTH / 4;
  logic [WIDTH-1:0] q_q, q_d;
  logic [NS:0] carry;
  logic valid_q, valid_d, ovr_q, ovr_d, wrap;
  logic [7:0] cnt_q, cnt_d;
  // carry[k] enables slice k; it ripples only through slices sitting at F
  assign carry[0] = enp & ent;
  genvar k;
  for (k = 0; k < NS; k++) begin : g_slice
    assign carry[k+1] = carry[k] & (&q_q[4*k +: 4]);
    assign q_d[4*k +: 4] = !clr_n ? 4'h0 :
                           !load_n ? d[4*k +: 4] :
                           carry[k] ? q_q[4*k +: 4] + 4'h1 : q_q[4*k +: 4];
  end
  // carry out of the top slice on a count edge is exactly a wrap
  assign wrap = clr_n & load_n & carry[NS];
  always_comb begin
    valid_d = wrap ? 1'b1 : (valid_q & tc_ready) ? 1'b0 : valid_q;
    ovr_d = !clr_n ? 1'b0 : (wrap & valid_q & !tc_ready) ? 1'b1 : ovr_q;
    cnt_d = !clr_n ? 8'h00 : (wrap && cnt_q != 8'hFF) ? cnt_q + 8'h01 : cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
      valid_q <= 1'b0;
      ovr_q <= 1'b0;
      cnt_q <= 8'h00;
    end else begin
      q_q <= q_d;
      valid_q <= valid_d;
      ovr_q <= ovr_d;
      cnt_q <= cnt_d;
    end
  end
  assign q = q_q;
  assign rco = ent & (&q_q);
  assign tc_valid = valid_q;
  assign tc_overrun = ovr_q;
  assign wrap_cnt = cnt_q;
endmodule

// File: tb/tb_cnt163_chain.sv
// tb_cnt163_chain: directed + random checks of a 16-bit and a 4-bit counter against an arithmetic model
module tb_cnt163_chain;
  logic clk = 1'b0, rst = 1'b1;
  logic clr_n = 1'b1, load_n = 1'b1, enp = 1'b0, ent = 1'b0, tc_ready = 1'b0;
  logic [15:0] d = 16'h0;
  logic [15:0] q16;
  logic [3:0] q4;
  logic rco16, rco4, v16, v4, o16, o4;
  logic [7:0] c16, c4;
  int checks = 0, errors = 0;
  int unsigned mq[2];
  bit mv[2], mo[2];
  int mc[2];
  int w[2] = '{16, 4};

  always #5 clk = ~clk;

  cnt163_chain #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .clr_n(clr_n), .load_n(load_n), .enp(enp), .ent(ent),
    .d(d), .q(q16), .rco(rco16), .tc_valid(v16), .tc_ready(tc_ready),
    .tc_overrun(o16), .wrap_cnt(c16)
  );
  cnt163_chain #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .clr_n(clr_n), .load_n(load_n), .enp(enp), .ent(ent),
    .d(d[3:0]), .q(q4), .rco(rco4), .tc_valid(v4), .tc_ready(tc_ready),
    .tc_overrun(o4), .wrap_cnt(c4)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int unsigned mx(input int i);
    return (32'd1 << w[i]) - 32'd1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i] = 0; mv[i] = 0; mo[i] = 0; mc[i] = 0;
    end
  endtask

  task automatic compare_all();
    chk("q16", 32'(q16), mq[0]);
    chk("q4", 32'(q4), mq[1]);
    chk("rco16", 32'(rco16), 32'(ent && mq[0] == mx(0)));
    chk("rco4", 32'(rco4), 32'(ent && mq[1] == mx(1)));
    chk("valid16", 32'(v16), 32'(mv[0]));
    chk("valid4", 32'(v4), 32'(mv[1]));
    chk("ovr16", 32'(o16), 32'(mo[0]));
    chk("ovr4", 32'(o4), 32'(mo[1]));
    chk("cnt16", 32'(c16), 32'(mc[0]));
    chk("cnt4", 32'(c4), 32'(mc[1]));
  endtask

  // apply inputs for one edge, advance the model by the counter rules, check 1ns after the edge
  task automatic step(input logic c, l, p, t, r, input logic [15:0] dv);
    bit wr;
    clr_n = c; load_n = l; enp = p; ent = t; tc_ready = r; d = dv;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      wr = c && l && p && t && mq[i] == mx(i);
      if (!c) begin
        mq[i] = 0; mc[i] = 0; mo[i] = 0;
      end else if (!l) mq[i] = 32'(dv) & mx(i);
      else if (p && t) mq[i] = (mq[i] + 1) & mx(i);
      if (wr) begin
        if (mv[i] && !r) mo[i] = 1;
        mv[i] = 1;
        if (mc[i] < 255) mc[i]++;
      end else if (mv[i] && r) mv[i] = 0;
    end
    #1 compare_all();
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 compare_all();
    rst = 1'b0;
    // load FFFD then three counts: FFFE, FFFF, 0000 with one wrap
    step(1, 0, 0, 0, 0, 16'hFFFD);
    for (int i = 0; i < 3; i++) step(1, 1, 1, 1, 0, 16'h0);
    chk("ld_cnt_q", 32'(q16), 32'h0);
    chk("ld_cnt_valid", 32'(v16), 32'h1);
    chk("ld_cnt_wraps", 32'(c16), 32'h1);
    // enable gating
    step(1, 0, 0, 0, 0, 16'h00FF);
    step(1, 1, 0, 1, 0, 16'h0);
    chk("gate_enp_q", 32'(q16), 32'h00FF);
    step(1, 0, 0, 0, 0, 16'hFFFF);
    step(1, 1, 1, 0, 0, 16'h0);
    chk("gate_ent_q", 32'(q16), 32'hFFFF);
    chk("gate_ent_rco", 32'(rco16), 32'h0);
    // handshake: accept without wrap, then wrap coinciding with accept
    step(1, 1, 0, 0, 1, 16'h0);
    chk("hs_accept", 32'(v16), 32'h0);
    step(1, 0, 0, 0, 0, 16'hFFFF);
    step(1, 1, 1, 1, 0, 16'h0);
    step(1, 0, 0, 0, 0, 16'hFFFF);
    step(1, 1, 1, 1, 1, 16'h0);
    chk("hs_coincide_valid", 32'(v16), 32'h1);
    chk("hs_coincide_ovr", 32'(o16), 32'h0);
    // overrun on the 4-bit counter: two wraps while not ready
    step(0, 1, 0, 0, 1, 16'h0);
    step(1, 1, 0, 0, 1, 16'h0);
    for (int i = 0; i < 32; i++) step(1, 1, 1, 1, 0, 16'h0);
    chk("ovr_valid", 32'(v4), 32'h1);
    chk("ovr_flag", 32'(o4), 32'h1);
    chk("ovr_wraps", 32'(c4), 32'h2);
    step(0, 1, 0, 0, 0, 16'h0);
    chk("clr_q", 32'(q4), 32'h0);
    chk("clr_ovr", 32'(o4), 32'h0);
    chk("clr_wraps", 32'(c4), 32'h0);
    chk("clr_valid", 32'(v4), 32'h1);
    // clear beats load
    step(0, 0, 1, 1, 0, 16'h1234);
    chk("prio_q", 32'(q16), 32'h0);
    // async reset between edges with an event pending
    step(1, 0, 0, 0, 0, 16'hFFFF);
    step(1, 1, 1, 1, 0, 16'h0);
    step(1, 0, 0, 0, 0, 16'h8000);
    chk("pre_rst_valid", 32'(v16), 32'h1);
    #2 rst = 1'b1;
    model_reset();
    #1 chk("rst_q", 32'(q16), 32'h0);
    chk("rst_valid", 32'(v16), 32'h0);
    load_n = 1'b1; enp = 1'b1; ent = 1'b1;
    @(posedge clk);
    #1 compare_all();
    rst = 1'b0;
    // random traffic
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 19) != 0), ($urandom_range(0, 9) != 0), 1'($urandom),
           ($urandom_range(0, 3) != 0), 1'($urandom), 16'($urandom));
    // saturation: 300 wraps of the 4-bit counter with the consumer always ready
    step(0, 1, 0, 0, 1, 16'h0);
    for (int i = 0; i < 300 * 16; i++) step(1, 1, 1, 1, 1, 16'h0);
    chk("sat_wraps", 32'(c4), 32'hFF);
    chk("sat_ovr", 32'(o4), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
